// File: rtl/ring_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ring_pkg
//  Description : Shared types and constants for the control-plane ring stop.
//                A packet is one 32-bit word:
//                  [31:30] type  [29:22] dst  [21:14] src  [13:0] payload
//                A type of 00 marks an empty slot. The all-zero word is the
//                canonical idle.
//  Revision    : 1.0  initial release
// ============================================================================
package ring_pkg;

  typedef enum logic [1:0] {
    PKT_IDLE = 2'b00,
    PKT_CTRL = 2'b01,
    PKT_ACK  = 2'b10,
    PKT_RSVD = 2'b11
  } pkt_type_e;

  typedef struct packed {
    pkt_type_e   ptype;
    logic [7:0]  dst;
    logic [7:0]  src;
    logic [13:0] payload;
  } packet_t;

  localparam logic [7:0]  BCAST_ID = 8'hFF;
  localparam logic [31:0] IDLE_PKT = 32'h0;

  // Any type-00 word occupies no slot, whatever its other bits hold.
  function automatic logic pkt_is_idle(input packet_t pkt);
    return pkt.ptype == PKT_IDLE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_inject_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_inject_fifo
//  Description : Synchronous FIFO that holds the node's outbound control
//                packets until the ring offers a free slot. Read and write
//                pointers carry one extra MSB so full and empty can be told
//                apart when the index bits coincide.
//  Ports       : clk, rst        clock, asynchronous active-high reset
//                push, push_data write request and word
//                pop             read request (ignored when empty)
//                full, empty     occupancy flags, decoded from pointer flops
//                head            word at the front of the queue
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_inject_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  generate
    if ((FIFO_DEPTH < 2) || ((1 << AW) != FIFO_DEPTH)) begin : g_depth_check
      $error("ctrl_inject_fifo: FIFO_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

  logic w_do_pop;
  logic w_do_push;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign head  = r_mem[r_rd_ptr[AW-1:0]];

  // A full queue still accepts a write when the same cycle frees a slot.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/control_ring_stop.sv
`default_nettype none
// ============================================================================
//  Module      : control_ring_stop
//  Description : Per-node stop on the control-plane ring. Each cycle the
//                word on ring_in is either delivered locally, forwarded to
//                ring_out, or dropped. Outbound packets from the local
//                Computer are queued and injected only into slots the ring
//                leaves free. All outputs are registered (1-cycle latency).
//  Ports       : clk, rst          clock, asynchronous active-high reset
//                node_id[7:0]      this node's id (upper bits ignored)
//                max_node[7:0]     ring node count (upper bits ignored)
//                ring_in/ring_out  upstream / downstream ring slots
//                local_tx_packet   outbound packet from the Computer
//                local_rx_packet   delivered packet, valid for one cycle
//                fifo_full         injection queue full
//                drop_count        returned/undeliverable/discarded packets
//                overflow_count    local packets lost to a full queue
//  Revision    : 1.0  initial release
// ============================================================================
module control_ring_stop
  import ring_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      node_id,
  input  logic [15:0]      max_node,
  input  logic [31:0]      ring_in,
  output logic [31:0]      ring_out,
  input  logic [31:0]      local_tx_packet,
  output logic [31:0]      local_rx_packet,
  output logic             fifo_full,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] overflow_count
);

  // Saturating add of a 0..2 increment; never wraps.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Input decode
  // --------------------------------------------------------------------------
  logic [7:0] w_nid;
  logic [7:0] w_max;
  logic       w_unused_hi;
  logic       w_degenerate;
  packet_t    w_rin;
  packet_t    w_tx;

  assign w_nid       = node_id[7:0];
  assign w_max       = max_node[7:0];
  assign w_unused_hi = ^{node_id[15:8], max_node[15:8]};
  assign w_rin       = ring_in;
  assign w_tx        = local_tx_packet;

  // An empty ring, or a node that claims the broadcast id, cannot route
  // anything: every ring packet is dropped and every injection discarded.
  assign w_degenerate = (w_max == 8'h00) || (w_nid == BCAST_ID);

  // --------------------------------------------------------------------------
  // Ring classifier, in priority order
  // --------------------------------------------------------------------------
  logic w_fwd;
  logic w_deliver;
  logic w_ring_drop;

  always_comb begin
    w_fwd       = 1'b0;
    w_deliver   = 1'b0;
    w_ring_drop = 1'b0;
    if (!pkt_is_idle(w_rin)) begin
      if (w_degenerate || (w_rin.src == w_nid)) begin
        // Returned to source; a broadcast arriving home also ends here.
        w_ring_drop = 1'b1;
      end else if (w_rin.dst == BCAST_ID) begin
        w_deliver = 1'b1;
        w_fwd     = 1'b1;
      end else if (w_rin.dst == w_nid) begin
        w_deliver = 1'b1;
      end else if (w_rin.dst >= w_max) begin
        w_ring_drop = 1'b1;
      end else begin
        w_fwd = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Injection queue
  // --------------------------------------------------------------------------
  logic    w_fifo_full;
  logic    w_fifo_empty;
  logic    w_pop;
  logic    w_tx_valid;
  logic    w_tx_discard;
  logic    w_push_req;
  logic    w_push;
  logic    w_overflow;
  packet_t w_push_pkt;
  packet_t w_head;

  // Forwarded traffic owns the slot; the queue only fills a free one. The
  // head is taken from flops, so a packet pushed this cycle cannot leave
  // until the next one.
  assign w_pop = !w_fwd && !w_fifo_empty;

  assign w_tx_valid   = !pkt_is_idle(w_tx);
  assign w_tx_discard = w_tx_valid &&
                        (w_degenerate ||
                         (w_tx.dst == w_nid) ||
                         ((w_tx.dst >= w_max) && (w_tx.dst != BCAST_ID)));
  assign w_push_req   = w_tx_valid && !w_tx_discard;
  assign w_push       = w_push_req && (!w_fifo_full || w_pop);
  assign w_overflow   = w_push_req && w_fifo_full && !w_pop;

  always_comb begin
    w_push_pkt     = w_tx;
    w_push_pkt.src = w_nid;
  end

  ctrl_inject_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (32)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_pkt),
    .pop       (w_pop),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .head      (w_head)
  );

  // The flag is decoded purely from the queue's pointer flops, so it already
  // shows the occupancy left by this cycle's push and pop.
  assign fifo_full = w_fifo_full;

  // --------------------------------------------------------------------------
  // Output registers and statistics
  // --------------------------------------------------------------------------
  logic [1:0] w_drop_inc;

  assign w_drop_inc = {1'b0, w_ring_drop} + {1'b0, w_tx_discard};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_out        <= IDLE_PKT;
      local_rx_packet <= IDLE_PKT;
      drop_count      <= '0;
      overflow_count  <= '0;
    end else begin
      if (w_fwd) begin
        ring_out <= ring_in;
      end else if (w_pop) begin
        ring_out <= w_head;
      end else begin
        ring_out <= IDLE_PKT;
      end
      local_rx_packet <= w_deliver ? ring_in : IDLE_PKT;
      drop_count      <= sat_add(drop_count, w_drop_inc);
      overflow_count  <= sat_add(overflow_count, {1'b0, w_overflow});
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_ring_stop.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_ring_stop
//  Description : Self-checking bench for control_ring_stop. Directed
//                scenarios plus a randomized run, all compared against a
//                queue-based reference model of the ring-stop rules.
//                Counters are built 4 bits wide so saturation is reachable.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_ring_stop;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [15:0]      node_id;
  logic [15:0]      max_node;
  logic [31:0]      ring_in;
  logic [31:0]      ring_out;
  logic [31:0]      local_tx_packet;
  logic [31:0]      local_rx_packet;
  logic             fifo_full;
  logic [CNT_W-1:0] drop_count;
  logic [CNT_W-1:0] overflow_count;

  int checks;
  int failures;

  control_ring_stop #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .node_id         (node_id),
    .max_node        (max_node),
    .ring_in         (ring_in),
    .ring_out        (ring_out),
    .local_tx_packet (local_tx_packet),
    .local_rx_packet (local_rx_packet),
    .fifo_full       (fifo_full),
    .drop_count      (drop_count),
    .overflow_count  (overflow_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: true (unbounded) event totals and a packet queue
  // --------------------------------------------------------------------------
  logic [31:0] mq[$];
  logic [31:0] m_out;
  logic [31:0] m_rx;
  int          m_drop;
  int          m_ovf;

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [7:0] d,
                                     input logic [7:0] s, input logic [13:0] p);
    return {t, d, s, p};
  endfunction

  function automatic logic [CNT_W-1:0] sat(input int v);
    return (v > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(v);
  endfunction

  task automatic model_clear();
    mq.delete();
    m_out  = 32'h0;
    m_rx   = 32'h0;
    m_drop = 0;
    m_ovf  = 0;
  endtask

  task automatic model_cycle(input logic [31:0] rin, input logic [31:0] tx);
    logic [7:0] nid;
    logic [7:0] mx;
    bit         dead;
    bit         fwd;
    logic [7:0] d;
    logic [7:0] s;
    logic [31:0] p;
    nid  = node_id[7:0];
    mx   = max_node[7:0];
    dead = (mx == 8'd0) || (nid == 8'hFF);
    fwd  = 0;
    m_rx = 32'h0;
    d    = rin[29:22];
    s    = rin[21:14];
    if (rin[31:30] != 2'b00) begin
      if (dead || s == nid)  m_drop++;
      else if (d == 8'hFF)   begin m_rx = rin; fwd = 1; end
      else if (d == nid)     m_rx = rin;
      else if (d >= mx)      m_drop++;
      else                   fwd = 1;
    end
    if (fwd)                 m_out = rin;
    else if (mq.size() > 0)  m_out = mq.pop_front();
    else                     m_out = 32'h0;
    if (tx[31:30] != 2'b00) begin
      d = tx[29:22];
      if (dead || d == nid || (d >= mx && d != 8'hFF)) m_drop++;
      else if (mq.size() >= FIFO_DEPTH)                m_ovf++;
      else begin
        p = tx;
        p[21:14] = nid;
        mq.push_back(p);
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return #1 later.
  task automatic step(input logic [31:0] rin, input logic [31:0] tx);
    ring_in         = rin;
    local_tx_packet = tx;
    @(posedge clk);
    model_cycle(rin, tx);
    #1;
    ring_in         = 32'h0;
    local_tx_packet = 32'h0;
  endtask

  task automatic do_reset(input logic [15:0] nid, input logic [15:0] mx);
    node_id         = nid;
    max_node        = mx;
    ring_in         = 32'h0;
    local_tx_packet = 32'h0;
    rst             = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    do_reset(16'd3, 16'd8);
    checks++; if (ring_out !== 32'h0) begin failures++; $display("FAIL reset_ring_out got=%h exp=0", ring_out); end
    checks++; if (local_rx_packet !== 32'h0) begin failures++; $display("FAIL reset_rx got=%h exp=0", local_rx_packet); end
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
    checks++; if (drop_count !== '0 || overflow_count !== '0) begin
      failures++; $display("FAIL reset_counters got drop=%0d ovf=%0d exp=0/0", drop_count, overflow_count);
    end
  endtask

  task automatic test_local_delivery();
    logic [31:0] p;
    do_reset(16'd3, 16'd8);
    p = mk(2'b01, 8'd3, 8'd1, 14'h0AB);
    step(p, 32'h0);
    checks++; if (local_rx_packet !== p) begin failures++; $display("FAIL deliver_rx got=%h exp=%h", local_rx_packet, p); end
    checks++; if (ring_out !== 32'h0) begin failures++; $display("FAIL deliver_ring_out got=%h exp=0", ring_out); end
    step(32'h0, 32'h0);
    checks++; if (local_rx_packet !== 32'h0) begin failures++; $display("FAIL deliver_rx_one_cycle got=%h exp=0", local_rx_packet); end
  endtask

  task automatic test_forward_priority();
    logic [31:0] p;
    logic [31:0] exp_loc;
    do_reset(16'd3, 16'd8);
    exp_loc = mk(2'b01, 8'd6, 8'd3, 14'h055);
    for (int i = 0; i < 4; i++) begin
      p = mk(2'b01, 8'd5, 8'd1, 14'(16 + i));
      step(p, (i == 0) ? mk(2'b01, 8'd6, 8'd0, 14'h055) : 32'h0);
      checks++; if (ring_out !== p) begin failures++; $display("FAIL fwd_ring_out[%0d] got=%h exp=%h", i, ring_out, p); end
    end
    step(32'h0, 32'h0);
    checks++; if (ring_out !== exp_loc) begin failures++; $display("FAIL fwd_inject got=%h exp=%h", ring_out, exp_loc); end
    step(32'h0, 32'h0);
    checks++; if (ring_out !== 32'h0) begin failures++; $display("FAIL fwd_after_inject got=%h exp=0", ring_out); end
  endtask

  task automatic test_overflow_order();
    logic [31:0] p;
    do_reset(16'd3, 16'd8);
    for (int i = 0; i < 5; i++) begin
      step(mk(2'b01, 8'd5, 8'd1, 14'(256 + i)), mk(2'b10, 8'd6, 8'd0, 14'(i)));
      if (i == 3) begin
        checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL ovf_full_after4 got=%b exp=1", fifo_full); end
        checks++; if (overflow_count !== '0) begin failures++; $display("FAIL ovf_none_yet got=%0d exp=0", overflow_count); end
      end
    end
    checks++; if (overflow_count !== CNT_W'(1)) begin failures++; $display("FAIL ovf_count got=%0d exp=1", overflow_count); end
    for (int j = 0; j < 4; j++) begin
      p = mk(2'b10, 8'd6, 8'd3, 14'(j));
      step(32'h0, 32'h0);
      checks++; if (ring_out !== p) begin failures++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", j, ring_out, p); end
    end
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL ovf_full_drained got=%b exp=0", fifo_full); end
  endtask

  task automatic test_broadcast();
    logic [31:0] p;
    do_reset(16'd3, 16'd8);
    p = mk(2'b01, 8'hFF, 8'd1, 14'h022);
    step(p, 32'h0);
    checks++; if (local_rx_packet !== p) begin failures++; $display("FAIL bcast_rx got=%h exp=%h", local_rx_packet, p); end
    checks++; if (ring_out !== p) begin failures++; $display("FAIL bcast_fwd got=%h exp=%h", ring_out, p); end
    step(mk(2'b01, 8'hFF, 8'd3, 14'h023), 32'h0);
    checks++; if (ring_out !== 32'h0 || local_rx_packet !== 32'h0) begin
      failures++; $display("FAIL bcast_home got out=%h rx=%h exp=0/0", ring_out, local_rx_packet);
    end
    checks++; if (drop_count !== CNT_W'(1)) begin failures++; $display("FAIL bcast_home_drop got=%0d exp=1", drop_count); end
  endtask

  task automatic test_undeliverable();
    do_reset(16'd3, 16'd8);
    step(mk(2'b01, 8'd9, 8'd2, 14'h001), mk(2'b01, 8'd3, 8'd0, 14'h002));
    checks++; if (drop_count !== CNT_W'(2)) begin failures++; $display("FAIL undeliv_double_drop got=%0d exp=2", drop_count); end
    checks++; if (ring_out !== 32'h0) begin failures++; $display("FAIL undeliv_ring_out got=%h exp=0", ring_out); end
    step(32'h0, 32'h0);
    checks++; if (ring_out !== 32'h0) begin failures++; $display("FAIL undeliv_not_queued got=%h exp=0", ring_out); end
  endtask

  task automatic test_degenerate();
    do_reset(16'd3, 16'd0);
    step(mk(2'b01, 8'hFF, 8'd1, 14'h010), mk(2'b01, 8'd2, 8'd0, 14'h011));
    checks++; if (ring_out !== 32'h0 || local_rx_packet !== 32'h0) begin
      failures++; $display("FAIL degen_out got out=%h rx=%h exp=0/0", ring_out, local_rx_packet);
    end
    checks++; if (drop_count !== CNT_W'(2)) begin failures++; $display("FAIL degen_drop got=%0d exp=2", drop_count); end
    node_id = 16'h00FF;
    max_node = 16'd8;
    step(mk(2'b01, 8'd2, 8'd1, 14'h012), 32'h0);
    checks++; if (ring_out !== 32'h0 || drop_count !== CNT_W'(3)) begin
      failures++; $display("FAIL degen_bcast_id got out=%h drop=%0d exp=0/3", ring_out, drop_count);
    end
  endtask

  task automatic test_saturation();
    do_reset(16'd3, 16'd8);
    for (int i = 0; i < 10; i++) begin
      step(mk(2'b01, 8'd200, 8'd1, 14'(i)), mk(2'b01, 8'd3, 8'd0, 14'(i)));
    end
    checks++; if (drop_count !== CNT_W'(CNT_MAX)) begin failures++; $display("FAIL sat_drop got=%0d exp=%0d", drop_count, CNT_MAX); end
    step(mk(2'b01, 8'd200, 8'd1, 14'h0), 32'h0);
    checks++; if (drop_count !== CNT_W'(CNT_MAX)) begin failures++; $display("FAIL sat_hold got=%0d exp=%0d", drop_count, CNT_MAX); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset(16'd3, 16'd8);
    for (int i = 0; i < 3; i++) begin
      step(mk(2'b01, 8'd5, 8'd1, 14'(i)), mk(2'b01, 8'd6, 8'd0, 14'(32 + i)));
    end
    step(mk(2'b01, 8'd9, 8'd1, 14'h0), 32'h0);
    step(mk(2'b01, 8'd5, 8'd1, 14'h7), 32'h0);
    rst = 1'b1;
    #1;
    checks++; if (ring_out !== 32'h0 || local_rx_packet !== 32'h0 || fifo_full !== 1'b0) begin
      failures++; $display("FAIL midrst_outputs got out=%h rx=%h full=%b exp=0", ring_out, local_rx_packet, fifo_full);
    end
    checks++; if (drop_count !== '0 || overflow_count !== '0) begin
      failures++; $display("FAIL midrst_counters got drop=%0d ovf=%0d exp=0/0", drop_count, overflow_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 6; i++) begin
      step(32'h0, 32'h0);
      checks++; if (ring_out !== 32'h0) begin failures++; $display("FAIL midrst_lost[%0d] got=%h exp=0", i, ring_out); end
    end
  endtask

  task automatic test_random();
    logic [15:0] nids[6];
    logic [15:0] mxs[6];
    logic [31:0] rin;
    logic [31:0] tx;
    logic [7:0]  nid;
    nids = '{16'd3, 16'd0, 16'd7, 16'd3, 16'h00FF, 16'h120A};
    mxs  = '{16'd8, 16'd4, 16'd8, 16'd0, 16'd8, 16'h01C8};
    do_reset(16'd3, 16'd8);
    for (int ph = 0; ph < 6; ph++) begin
      node_id  = nids[ph];
      max_node = mxs[ph];
      nid      = nids[ph][7:0];
      for (int c = 0; c < 80; c++) begin
        rin = 32'h0;
        tx  = 32'h0;
        if ($urandom_range(0, 9) < 7) begin
          rin[31:30] = 2'($urandom_range(1, 3));
          case ($urandom_range(0, 3))
            0: rin[29:22] = nid;
            1: rin[29:22] = 8'hFF;
            2: rin[29:22] = 8'($urandom_range(0, 9));
            default: rin[29:22] = 8'($urandom_range(0, 255));
          endcase
          rin[21:14] = ($urandom_range(0, 4) == 0) ? nid : 8'($urandom_range(0, 9));
          rin[13:0]  = 14'($urandom);
        end else if ($urandom_range(0, 1) == 0) begin
          rin[29:0] = 30'($urandom);
        end
        if ($urandom_range(0, 1) == 0) begin
          tx = $urandom;
          if ($urandom_range(0, 1) == 0) tx[29:22] = 8'($urandom_range(0, 9));
        end
        step(rin, tx);
        checks++; if (ring_out !== m_out) begin failures++; $display("FAIL rand_ring_out ph=%0d c=%0d got=%h exp=%h", ph, c, ring_out, m_out); end
        checks++; if (local_rx_packet !== m_rx) begin failures++; $display("FAIL rand_rx ph=%0d c=%0d got=%h exp=%h", ph, c, local_rx_packet, m_rx); end
        checks++; if (fifo_full !== (mq.size() == FIFO_DEPTH)) begin failures++; $display("FAIL rand_full ph=%0d c=%0d got=%b exp=%b", ph, c, fifo_full, (mq.size() == FIFO_DEPTH)); end
        checks++; if (drop_count !== sat(m_drop)) begin failures++; $display("FAIL rand_drop ph=%0d c=%0d got=%0d exp=%0d", ph, c, drop_count, sat(m_drop)); end
        checks++; if (overflow_count !== sat(m_ovf)) begin failures++; $display("FAIL rand_ovf ph=%0d c=%0d got=%0d exp=%0d", ph, c, overflow_count, sat(m_ovf)); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    node_id         = 16'd3;
    max_node        = 16'd8;
    ring_in         = 32'h0;
    local_tx_packet = 32'h0;
    model_clear();
    test_reset();
    test_local_delivery();
    test_forward_priority();
    test_overflow_order();
    test_broadcast();
    test_undeliverable();
    test_degenerate();
    test_saturation();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
